// File: rtl/memctl_arb_pkg.sv
// Shared types and default sizing for the per-bank request queues feeding the
// bank-group arbiter.
package memctl_arb_pkg;

    localparam int unsigned DefaultDataW   = 32;
    localparam int unsigned DefaultDepth   = 16;
    localparam int unsigned DefaultThresh  = 4;
    localparam int unsigned DefaultTimeout = 64;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StFill = 2'd1,
        StReq  = 2'd2
    } bank_q_state_e;

endpackage

// File: rtl/bank_q_storage.sv
// DEPTH x DATA_W entry array for one bank queue: one write port, one
// asynchronous read port. Contents are not reset.
module bank_q_storage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [DATA_W-1:0]        rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/bank_req_queue.sv
// Per-bank request queue with burst request FSM (IDLE/FILL/REQ) for the
// bank-group arbiter. Define BANK_Q_AGING_EN to build the FILL aging timeout.
module bank_req_queue
    import memctl_arb_pkg::*;
#(
    parameter int unsigned DATA_W  = DefaultDataW,
    parameter int unsigned DEPTH   = DefaultDepth,
    parameter int unsigned THRESH  = DefaultThresh,
    parameter int unsigned TIMEOUT = DefaultTimeout
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid_i,
    input  logic [DATA_W-1:0]        in_data_i,
    output logic                     in_ready_o,
    input  logic                     drain_i,
    output logic [DATA_W-1:0]        out_data_o,
    output logic                     out_valid_o,
    output logic                     bank_req_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthCnt  = CntW'(DEPTH);
    localparam logic [CntW-1:0] ThreshCnt = CntW'(THRESH);

    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q, count_d;
    logic            push, pop;
    logic            age_hit;
    logic            bank_req_q;
    bank_q_state_e   state_q;

    // A full queue refuses pushes even if a pop frees a slot this cycle.
    assign in_ready_o  = (count_q < DepthCnt);
    assign out_valid_o = (count_q != '0);
    assign push        = in_valid_i & in_ready_o;
    assign pop         = drain_i & out_valid_o;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    bank_q_storage #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_storage (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (in_data_i),
        .raddr_i (rd_ptr_q),
        .rdata_o (out_data_o)
    );

`ifdef BANK_Q_AGING_EN
    localparam int unsigned AgeW = $clog2(TIMEOUT + 1);
    localparam logic [AgeW-1:0] AgeMax = AgeW'(TIMEOUT);

    logic [AgeW-1:0] age_q, age_d;

    // Trigger on the edge where the age reaches TIMEOUT so REQ follows directly.
    assign age_d   = (age_q == AgeMax) ? age_q : age_q + 1'b1;
    assign age_hit = (age_d == AgeMax);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            age_q <= '0;
        end else if (state_q == StFill) begin
            age_q <= age_d;
        end else begin
            age_q <= '0;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign age_hit        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            bank_req_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (out_valid_o) state_q <= StFill;
                end
                StFill: begin
                    if (count_d == '0) begin
                        state_q <= StIdle;
                    end else if ((count_d >= ThreshCnt) || age_hit) begin
                        state_q    <= StReq;
                        bank_req_q <= 1'b1;
                    end
                end
                StReq: begin
                    if (count_d == '0) begin
                        state_q    <= StIdle;
                        bank_req_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= StIdle;
                    bank_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign bank_req_o = bank_req_q;
    assign count_o    = count_q;

endmodule

// File: doc/bank_req_queue.md
BANK_REQ_QUEUE -- requirements
Module: bank_req_queue

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the width of one request entry.
REQ-002 Parameter DEPTH, default 16, SHALL set the entry count and SHALL be a power of two, at least 4.
REQ-003 Parameter THRESH, default 4, SHALL set the occupancy that raises bank_req; valid range is 1..DEPTH.
REQ-004 Parameter TIMEOUT, default 64, SHALL set the aging limit in cycles; valid range is at least 1.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 in_valid  in  1  upstream request valid.
REQ-008 in_data  in  DATA_W  upstream request payload.
REQ-009 in_ready  out  1  queue accepts a push this cycle.
REQ-010 drain  in  1  bank-group arbiter pops the head this cycle (its enable qualified by its bank select matching this bank).
REQ-011 out_data  out  DATA_W  head entry, combinational read.
REQ-012 out_valid  out  1  queue is non-empty; feeds the arbiter valid bit for this bank.
REQ-013 bank_req  out  1  burst request to the bank-group arbiter.
REQ-014 count  out  $clog2(DEPTH)+1  current occupancy.

Function
REQ-015 A push SHALL occur when in_valid and in_ready are both high; in_ready SHALL equal (count < DEPTH).
REQ-016 A pop SHALL occur when drain and out_valid are both high; drain while empty SHALL be ignored.
REQ-017 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-018 While full, in_valid SHALL be rejected even when a pop occurs in the same cycle.
REQ-019 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or go below 0.
REQ-020 A pushed entry SHALL appear at out_data, with out_valid high, in the cycle after the push.
REQ-021 Request FSM states SHALL be IDLE, FILL and REQ, registered.
REQ-022 IDLE SHALL go to FILL on the cycle after the first push.
REQ-023 FILL SHALL go to REQ when count >= THRESH, or when the age counter equals TIMEOUT (aging builds only).
REQ-024 FILL SHALL go to IDLE if the queue empties.
REQ-025 REQ SHALL hold while count > 0; when count reaches 0, REQ SHALL go to IDLE on the same edge.
REQ-026 bank_req SHALL be high exactly while the state is REQ, so the arbiter sees the request stay up through the whole burst.
REQ-027 The age counter SHALL clear on entry to FILL, increment each cycle in FILL, saturate at TIMEOUT, and clear in IDLE and REQ.
REQ-028 A push during REQ SHALL extend the current burst and SHALL NOT restart aging.

Reset
REQ-029 On rst_n low at a clock edge, the following SHALL be cleared: state to IDLE, count to 0, pointers to 0, age to 0.
REQ-030 The resulting reset outputs SHALL be in_ready=1, out_valid=0, bank_req=0 and count=0.
REQ-031 Reset mid-burst SHALL discard all entries; storage contents need no reset.

Configuration
REQ-032 Macro BANK_Q_AGING_EN defined: the age counter and the TIMEOUT trigger of REQ-023 SHALL be present.
REQ-033 Macro BANK_Q_AGING_EN undefined: no age logic SHALL be built, TIMEOUT SHALL be unused, and FILL SHALL leave only on count >= THRESH or on becoming empty.

Structure
REQ-034 Package memctl_arb_pkg SHALL hold the state enum (IDLE/FILL/REQ) and the default DEPTH, THRESH and TIMEOUT constants.
REQ-035 Storage SHALL be a sub-module, bank_q_storage: a DEPTH x DATA_W array with one write port and one asynchronous read port.
REQ-036 Four instances SHALL feed one bank-group arbiter, ordered A..D.

Verification
REQ-037 Directed scenarios (THRESH=4, DEPTH=16, TIMEOUT=64 unless stated):
- 3 pushes, no drain, aging built -> bank_req rises 64 cycles after FILL entry; drain 3 -> bank_req low the cycle after the 3rd pop.
- 4 back-to-back pushes -> bank_req high the cycle after the 4th push; out_data shows the first payload.
- Fill to 16 -> in_ready=0; a 17th push with simultaneous drain is rejected and count=15.
- Push and drain every cycle, 40 cycles -> count constant and data order preserved across pointer wrap.
- Reset asserted in REQ with count=9 -> next cycle count=0, bank_req=0, out_valid=0.
- Aging not built, 3 pushes held 200 cycles -> bank_req stays 0; 4th push -> bank_req high.
